// File: rtl/pixel_unpacker_8bit.sv
// Frame-buffer read side of the quantized-color path: walks the buffer in raster
// order alongside `visible`, unpacks two nibbles per byte and expands each to 8 bits.
module pixel_unpacker_8bit #(
  parameter int H_VISIBLE = 1024,
  parameter int V_VISIBLE = 768,
  parameter int ADDR_W    = 19,
  parameter int REPLICATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              visible,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_data,
  output logic [7:0]        salida_color_8_bit,
  output logic              visible_out
);

  localparam int FRAME_BYTES = (H_VISIBLE * V_VISIBLE) / 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  // Nibble back to 8-bit color: replicate for full scale, or zero-fill to match the quantizer.
  function automatic logic [7:0] expand_nibble(input logic [3:0] n);
    logic [7:0] c;
    if (REPLICATE != 0) begin
      c = {n, n};
    end else begin
      c = {n, 4'd0};
    end
    return c;
  endfunction

  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic              phase_q, phase_d;
  logic              vis_d1_q, vis_d2_q, phase_d1_q, phase_d1_d;
  logic [7:0]        hold_byte_q, hold_byte_d;
  logic [7:0]        color_q, color_d;
  logic              vis_out_q;
  logic              phase_eff_s;
  logic [ADDR_W-1:0] base_addr_s;
  logic [3:0]        nibble_s;

  // Address walker: frame_start rewinds to pixel 0 in the same cycle it arrives.
  always_comb begin
    phase_eff_s = phase_q;
    base_addr_s = addr_cnt_q;
    if (frame_start) begin
      phase_eff_s = 1'b0;
      base_addr_s = '0;
    end else begin
      phase_eff_s = phase_q;
      base_addr_s = addr_cnt_q;
    end

    addr_cnt_d = base_addr_s;
    phase_d    = 1'b0;
    if (visible) begin
      if (!phase_eff_s) begin
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (base_addr_s == LAST_ADDR) begin
          addr_cnt_d = '0;
        end else begin
          addr_cnt_d = base_addr_s + ADDR_W'(1);
        end
      end
    end else begin
      phase_d = 1'b0;
    end

    mem_addr  = base_addr_s;
    mem_rd_en = visible & ~phase_eff_s & ~rst;
  end

  // Unpack: even pixel comes straight from the returning byte, odd pixel from the held copy.
  always_comb begin
    phase_d1_d  = phase_eff_s;
    hold_byte_d = hold_byte_q;
    if (vis_d1_q && !phase_d1_q) begin
      hold_byte_d = mem_data;
    end else begin
      hold_byte_d = hold_byte_q;
    end

    if (!phase_d1_q) begin
      nibble_s = mem_data[7:4];
    end else begin
      nibble_s = hold_byte_q[3:0];
    end

    if (vis_d1_q) begin
      color_d = expand_nibble(nibble_s);
    end else begin
      color_d = 8'd0;
    end
  end

  // Pipeline and state registers with synchronous flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt_q  <= '0;
      phase_q     <= 1'b0;
      vis_d1_q    <= 1'b0;
      vis_d2_q    <= 1'b0;
      phase_d1_q  <= 1'b0;
      hold_byte_q <= 8'd0;
      color_q     <= 8'd0;
      vis_out_q   <= 1'b0;
    end else begin
      addr_cnt_q  <= addr_cnt_d;
      phase_q     <= phase_d;
      vis_d1_q    <= visible;
      vis_d2_q    <= vis_d1_q;
      phase_d1_q  <= phase_d1_d;
      hold_byte_q <= hold_byte_d;
      color_q     <= color_d;
      vis_out_q   <= vis_d1_q;
    end
  end

  assign salida_color_8_bit = color_q;
  assign visible_out        = vis_out_q;

endmodule

// File: tb/tb_pixel_unpacker_8bit.sv
// Directed table-driven bench: two instances (replicate and zero-fill expansion)
// on a 4x2 frame, each fed by its own 1-cycle-latency memory model.
module tb_pixel_unpacker_8bit;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          visible = 1'b0;
  logic          frame_start = 1'b0;
  logic [AW-1:0] addr_rep, addr_trn;
  logic          rd_rep, rd_trn;
  logic [7:0]    data_rep = 8'h00;
  logic [7:0]    data_trn = 8'h00;
  logic [7:0]    col_rep, col_trn;
  logic          vo_rep, vo_trn;
  logic [7:0]    mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_unpacker_8bit #(.H_VISIBLE(4), .V_VISIBLE(2), .ADDR_W(AW), .REPLICATE(1)) u_rep (
    .clk(clk), .rst(rst), .visible(visible), .frame_start(frame_start),
    .mem_addr(addr_rep), .mem_rd_en(rd_rep), .mem_data(data_rep),
    .salida_color_8_bit(col_rep), .visible_out(vo_rep)
  );

  pixel_unpacker_8bit #(.H_VISIBLE(4), .V_VISIBLE(2), .ADDR_W(AW), .REPLICATE(0)) u_trn (
    .clk(clk), .rst(rst), .visible(visible), .frame_start(frame_start),
    .mem_addr(addr_trn), .mem_rd_en(rd_trn), .mem_data(data_trn),
    .salida_color_8_bit(col_trn), .visible_out(vo_trn)
  );

  // Frame-buffer models: data appears one cycle after a read strobe.
  always @(posedge clk) begin
    if (rd_rep) data_rep <= mem[addr_rep];
    if (rd_trn) data_trn <= mem[addr_trn];
  end

  typedef struct {
    logic       rst;
    logic       fs;
    logic       vis;
    logic       rd;
    logic [3:0] addr;
    logic [7:0] c_rep;
    logic [7:0] c_trn;
    logic       vo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic f, input logic v, input logic rd,
                              input logic [3:0] a, input logic [7:0] cr, input logic [7:0] ct,
                              input logic vo);
    vec_t x;
    x.rst = r; x.fs = f; x.vis = v; x.rd = rd; x.addr = a;
    x.c_rep = cr; x.c_trn = ct; x.vo = vo;
    return x;
  endfunction

  task automatic check(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic check_all(input int row, input vec_t e);
    check("rd_en",     row, {7'd0, rd_rep}, {7'd0, e.rd});
    check("rd_en_trn", row, {7'd0, rd_trn}, {7'd0, e.rd});
    check("addr",      row, {4'd0, addr_rep}, {4'd0, e.addr});
    check("color_rep", row, col_rep, e.c_rep);
    check("color_trn", row, col_trn, e.c_trn);
    check("vis_out",   row, {7'd0, vo_rep}, {7'd0, e.vo});
    check("vis_out_t", row, {7'd0, vo_trn}, {7'd0, e.vo});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hE0 + 8'(i);
    mem[0] = 8'hA5; mem[1] = 8'h3F; mem[2] = 8'h12; mem[3] = 8'hC7;

    //                rst fs vis  rd addr  rep    trn    vo
    vecs.push_back(mk(1, 0, 1,   0, 4'd0, 8'h00, 8'h00, 0)); // 0 reset with visible
    vecs.push_back(mk(1, 0, 1,   0, 4'd0, 8'h00, 8'h00, 0));
    vecs.push_back(mk(1, 0, 1,   0, 4'd0, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 1, 0,   0, 4'd0, 8'h00, 8'h00, 0)); // 3 frame_start
    vecs.push_back(mk(0, 0, 1,   1, 4'd0, 8'h00, 8'h00, 0)); // 4 line 0
    vecs.push_back(mk(0, 0, 1,   0, 4'd0, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 0, 1,   1, 4'd1, 8'hAA, 8'hA0, 1));
    vecs.push_back(mk(0, 0, 1,   0, 4'd1, 8'h55, 8'h50, 1));
    vecs.push_back(mk(0, 0, 0,   0, 4'd2, 8'h33, 8'h30, 1)); // 8 blanking x3
    vecs.push_back(mk(0, 0, 0,   0, 4'd2, 8'hFF, 8'hF0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 4'd2, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 0, 1,   1, 4'd2, 8'h00, 8'h00, 0)); // 11 line 1
    vecs.push_back(mk(0, 0, 1,   0, 4'd2, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 0, 1,   1, 4'd3, 8'h11, 8'h10, 1));
    vecs.push_back(mk(0, 0, 1,   0, 4'd3, 8'h22, 8'h20, 1));
    vecs.push_back(mk(0, 0, 0,   0, 4'd0, 8'hCC, 8'hC0, 1)); // 15 addr wrapped
    vecs.push_back(mk(0, 0, 0,   0, 4'd0, 8'h77, 8'h70, 1));
    vecs.push_back(mk(0, 0, 1,   1, 4'd0, 8'h00, 8'h00, 0)); // 17 frame 2, no frame_start
    vecs.push_back(mk(0, 0, 1,   0, 4'd0, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 0, 1,   1, 4'd1, 8'hAA, 8'hA0, 1));
    vecs.push_back(mk(0, 0, 1,   0, 4'd1, 8'h55, 8'h50, 1));
    vecs.push_back(mk(0, 0, 0,   0, 4'd2, 8'h33, 8'h30, 1));
    vecs.push_back(mk(0, 0, 1,   1, 4'd2, 8'hFF, 8'hF0, 1));
    vecs.push_back(mk(0, 0, 1,   0, 4'd2, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 1, 1,   1, 4'd0, 8'h11, 8'h10, 1)); // 24 frame_start+visible at addr 3
    vecs.push_back(mk(0, 0, 1,   0, 4'd0, 8'h22, 8'h20, 1));
    vecs.push_back(mk(0, 0, 1,   1, 4'd1, 8'hAA, 8'hA0, 1));
    vecs.push_back(mk(0, 0, 1,   0, 4'd1, 8'h55, 8'h50, 1));
    vecs.push_back(mk(1, 0, 1,   0, 4'd2, 8'h33, 8'h30, 1)); // 28 mid-frame reset
    vecs.push_back(mk(0, 0, 1,   1, 4'd0, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 0, 1,   0, 4'd0, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 0, 0,   0, 4'd1, 8'hAA, 8'hA0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 4'd1, 8'h55, 8'h50, 1));
    vecs.push_back(mk(0, 0, 0,   0, 4'd1, 8'h00, 8'h00, 0));

    // Initial reset before the table starts.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      frame_start = vecs[i].fs;
      visible = vecs[i].vis;
      #1;
      check_all(i, vecs[i]);
      @(negedge clk);
    end

    // Odd-length burst: a lone visible pixel, blanking, then the next read reuses the same byte.
    rst = 1'b0; frame_start = 1'b0;
    visible = 1'b1; #1;
    check("odd_rd_a",   100, {7'd0, rd_rep}, 8'd1);
    check("odd_addr_a", 100, {4'd0, addr_rep}, 8'd1);
    @(negedge clk);
    visible = 1'b0; #1;
    check("odd_rd_b",   101, {7'd0, rd_rep}, 8'd0);
    @(negedge clk);
    visible = 1'b1; #1;
    check("odd_col_a",  102, col_rep, 8'h33);
    check("odd_col_t",  102, col_trn, 8'h30);
    check("odd_rd_c",   102, {7'd0, rd_rep}, 8'd1);
    check("odd_addr_c", 102, {4'd0, addr_rep}, 8'd1);
    @(negedge clk);
    visible = 1'b0; #1;
    check("odd_col_b",  103, col_rep, 8'h00);
    @(negedge clk);
    #1;
    check("odd_col_c",  104, col_rep, 8'h33);
    check("odd_vo_c",   104, {7'd0, vo_rep}, 8'd1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
